// File: rtl/window_feeder.sv
// window_feeder: raster pixel stream to 3x3 neighbourhood windows with edge replication.
// Two line buffers plus a 3-column shift register form a 2*IMG_W+3 pixel history.
module window_feeder #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    input  logic       pix_sof,
    output logic       pix_ready,
    output logic       win_valid,
    output logic [7:0] pixel,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    input  logic       rd_en,
    output logic       frame_done,
    output logic       rd_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [RW-1:0] R_ONE = RW'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] in_c, out_c, addr;
    logic [RW-1:0] in_r, out_r;
    logic [7:0]    lb_a [IMG_W];
    logic [7:0]    lb_b [IMG_W];
    logic [7:0]    sr1 [3];
    logic [7:0]    sr2 [3];
    logic [7:0]    t [3][3];
    logic [7:0]    win [9];
    logic [7:0]    win_nxt [9];
    logic [1:0]    ri [3];
    logic [1:0]    ci [3];
    logic          last, accept, sof_acc, fl_load, adv, load, in_end;

    assign pix_ready  = rst_n & (state == RUN ? (!win_valid | rd_en) : state != FLUSH);
    assign accept     = pix_valid & pix_ready;
    assign sof_acc    = accept & pix_sof;
    assign in_end     = in_r == R_LAST && in_c == C_LAST;
    assign fl_load    = state == FLUSH && !last && (!win_valid || rd_en);
    assign adv        = (accept && (pix_sof || state != IDLE)) || fl_load;
    assign load       = (accept && !pix_sof && (state == RUN ||
                        (state == FILL && in_r == R_ONE && in_c == C_ONE))) || fl_load;
    assign frame_done = win_valid & rd_en & last;
    assign addr       = sof_acc ? '0 : in_c;

    assign {p1, p2, p3, p4, pixel, p5, p6, p7, p8} =
        {win[0], win[1], win[2], win[3], win[4], win[5], win[6], win[7], win[8]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sof_acc) state_nxt = FILL;
            FILL:    if (load) state_nxt = RUN;
            RUN:     if (sof_acc) state_nxt = FILL;
                     else if (accept && in_end) state_nxt = FLUSH;
            FLUSH:   if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // t[row][col]: rows r-1..r+1, cols c-1..c+1 of the window being loaded, before clamping
    always_comb begin
        t[0][2] = lb_b[addr];
        t[1][2] = lb_a[addr];
        t[2][2] = pix_in;
        for (int x = 0; x < 3; x++) begin
            t[x][1] = sr1[x];
            t[x][0] = sr2[x];
        end
        ri[0] = out_r == '0 ? 2'd1 : 2'd0;
        ri[1] = 2'd1;
        ri[2] = out_r == R_LAST ? 2'd1 : 2'd2;
        ci[0] = out_c == '0 ? 2'd1 : 2'd0;
        ci[1] = 2'd1;
        ci[2] = out_c == C_LAST ? 2'd1 : 2'd2;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                win_nxt[3*a+b] = t[ri[a]][ci[b]];
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            lb_a[addr] <= pix_in;
            lb_b[addr] <= lb_a[addr];
            for (int x = 0; x < 3; x++) begin
                sr1[x] <= t[x][2];
                sr2[x] <= sr1[x];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_c      <= '0;
            in_r      <= '0;
            out_c     <= '0;
            out_r     <= '0;
            win_valid <= 1'b0;
            last      <= 1'b0;
            rd_err    <= 1'b0;
            for (int x = 0; x < 9; x++) win[x] <= '0;
        end else begin
            state     <= state_nxt;
            rd_err    <= rd_err | (rd_en & !win_valid);
            win_valid <= sof_acc ? 1'b0 : load | (win_valid & !rd_en);
            if (sof_acc) begin
                in_c <= C_ONE;
                in_r <= '0;
            end else if (adv) begin
                in_c <= in_c == C_LAST ? '0 : in_c + C_ONE;
                in_r <= in_c != C_LAST ? in_r : (in_r == R_LAST ? '0 : in_r + R_ONE);
            end
            if (sof_acc) begin
                out_c <= '0;
                out_r <= '0;
                last  <= 1'b0;
            end else if (load) begin
                out_c <= out_c == C_LAST ? '0 : out_c + C_ONE;
                out_r <= out_c != C_LAST ? out_r : (out_r == R_LAST ? '0 : out_r + R_ONE);
                last  <= out_r == R_LAST && out_c == C_LAST;
                for (int x = 0; x < 9; x++) win[x] <= win_nxt[x];
            end
        end
    end
endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: random and directed frames against a clamped-coordinate frame model.
module tb_window_feeder;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       pix_valid = 1'b0, pix_sof = 1'b0, rd_en = 1'b0;
    logic [7:0] pix_in = '0;
    logic       pix_ready, win_valid, frame_done, rd_err;
    logic [7:0] pixel, p1, p2, p3, p4, p5, p6, p7, p8;

    int vectors = 0, errors = 0;
    int nacc = 0, k = 0, v_pct = 100, rd_pct = 100, done_seen = 0;
    bit in_frame = 0, err_m = 0;
    logic [7:0] fpix [N];
    logic [7:0] pv [N];

    window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .win_valid(win_valid), .pixel(pixel),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .rd_en(rd_en), .frame_done(frame_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mp(int r, int c);
        int rr = r < 0 ? 0 : (r >= H ? H - 1 : r);
        int cc = c < 0 ? 0 : (c >= W ? W - 1 : c);
        return fpix[rr*W+cc];
    endfunction

    function automatic logic [71:0] mwin(int kk);
        int r = kk / W;
        int c = kk % W;
        return {mp(r-1, c-1), mp(r-1, c), mp(r-1, c+1), mp(r, c-1), mp(r, c),
                mp(r, c+1), mp(r+1, c-1), mp(r+1, c), mp(r+1, c+1)};
    endfunction

    // One cycle: drive, predict handshake from frame progress counts, compare, update model.
    task automatic step(input bit v, input bit sof, input logic [7:0] px, input bit rd, output bit acc);
        bit er, ev, ef, cons;
        logic [71:0] got;
        @(negedge clk);
        pix_valid = v; pix_sof = sof; pix_in = px; rd_en = rd;
        #1;
        if (!in_frame || nacc < W + 2) begin
            er = 1; ev = 0;
        end else if (nacc < N) begin
            ev = (nacc - W - 1) > k; er = !ev || rd;
        end else begin
            ev = 1; er = 0;
        end
        ef = ev && rd && k == N - 1;
        vectors += 4;
        if (pix_ready !== er) begin errors++; $display("FAIL pix_ready got %b want %b nacc=%0d k=%0d", pix_ready, er, nacc, k); end
        if (win_valid !== ev) begin errors++; $display("FAIL win_valid got %b want %b nacc=%0d k=%0d", win_valid, ev, nacc, k); end
        if (frame_done !== ef) begin errors++; $display("FAIL frame_done got %b want %b k=%0d", frame_done, ef, k); end
        if (rd_err !== err_m) begin errors++; $display("FAIL rd_err got %b want %b", rd_err, err_m); end
        if (frame_done) done_seen++;
        if (ev) begin
            vectors++;
            got = {p1, p2, p3, p4, pixel, p5, p6, p7, p8};
            if (got !== mwin(k)) begin errors++; $display("FAIL window k=%0d got %h want %h", k, got, mwin(k)); end
        end
        err_m |= rd && !ev;
        cons = ev && rd;
        acc = v && er;
        if (cons) begin k++; if (k == N) in_frame = 0; end
        if (acc) begin
            if (sof) begin in_frame = 1; fpix[0] = px; nacc = 1; k = 0; end
            else if (in_frame && nacc < N) begin fpix[nacc] = px; nacc++; end
        end
    endtask

    task automatic stream_frame(input int abort_at, input int stall_at, input bit seq);
        int i = 0, cyc = 0, stall = 0;
        bit acc, v, rd;
        for (int j = 0; j < N; j++) pv[j] = seq ? 8'(j + 1) : 8'($urandom);
        while (i < N && i != abort_at && cyc < 2000) begin
            v = $urandom_range(99) < v_pct;
            rd = $urandom_range(99) < rd_pct;
            if (i == stall_at && stall < 5) begin v = 1; rd = 0; stall++; end
            step(v, i == 0, pv[i], rd, acc);
            if (acc) i++;
            cyc++;
        end
        if (abort_at < 0)
            while (in_frame && cyc < 4000) begin
                rd = $urandom_range(99) < rd_pct;
                step(0, 0, 8'h00, rd, acc);
                cyc++;
            end
        vectors++;
        if (abort_at < 0 ? (in_frame || i < N) : i != abort_at) begin
            errors++; $display("FAIL frame_progress accepted %0d windows %0d within budget", i, k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; pix_valid = 0; pix_sof = 0; rd_en = 0;
        #1;
        vectors += 3;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", pix_ready); end
        if ({win_valid, frame_done, rd_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {win_valid, frame_done, rd_err});
        end
        if ({pixel, p1, p2, p3, p4, p5, p6, p7, p8} !== 72'h0) begin
            errors++; $display("FAIL reset_window got %h want 0", {pixel, p1, p2, p3, p4, p5, p6, p7, p8});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        in_frame = 0; err_m = 0; nacc = 0; k = 0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_idle_rd_err();
        bit acc;
        step(0, 0, 8'h00, 0, acc);
        step(0, 0, 8'h00, 1, acc);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h55, 0, acc);
        step(0, 0, 8'h00, 0, acc);
    endtask

    task automatic test_directed();
        v_pct = 100; rd_pct = 100; done_seen = 0;
        stream_frame(-1, -1, 1);
        vectors++;
        if (done_seen !== 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", done_seen); end
    endtask

    task automatic test_stall();
        v_pct = 100; rd_pct = 100;
        stream_frame(-1, 8, 0);
    endtask

    task automatic test_abort();
        v_pct = 100; rd_pct = 100;
        stream_frame(7, -1, 1);
        stream_frame(-1, -1, 1);
    endtask

    task automatic test_reset_mid_run();
        v_pct = 100; rd_pct = 100;
        stream_frame(9, -1, 0);
        do_reset();
        stream_frame(-1, -1, 0);
    endtask

    task automatic test_random();
        v_pct = 70; rd_pct = 60;
        for (int f = 0; f < 4; f++) stream_frame(-1, $urandom_range(2, N - 2), 0);
        stream_frame($urandom_range(3, N - 1), -1, 0);
        stream_frame(-1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_idle_rd_err();
        test_directed();
        test_stall();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
